// File: rtl/fetch_pkg.sv
// Shared types and memory-map helpers for the instruction fetch stage.
// The address map constants here are the defaults for the top-level parameters.
package fetch_pkg;

  localparam logic [31:0] RAM_TOP  = 32'h0003_FFFF;
  localparam logic [31:0] ROM_BASE = 32'h0004_0000;
  localparam logic [31:0] ROM_TOP  = 32'h0007_FFFF;
  localparam logic [31:0] IO_BASE  = 32'h0008_0000;
  localparam logic [31:0] IO_TOP   = 32'h0008_FFFF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  // RAM starts at address 0, so the RAM check only needs its upper bound.
  function automatic logic is_executable(input logic [31:0] addr,
                                         input logic [31:0] ram_top  = RAM_TOP,
                                         input logic [31:0] rom_base = ROM_BASE,
                                         input logic [31:0] rom_top  = ROM_TOP);
    return (addr <= ram_top) || ((addr >= rom_base) && (addr <= rom_top));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries with synchronous flush.
// Pointers are log2(DEPTH) bits wide and wrap naturally; count is one bit wider.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  fetch_entry_t       mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        cnt;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the same-cycle memory and queues
// {pc, instr, fault} entries for decode. Redirects flush the queue and reload the PC.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0004_0000,
  parameter logic [31:0] RAM_TOP  = fetch_pkg::RAM_TOP,
  parameter logic [31:0] ROM_BASE = fetch_pkg::ROM_BASE,
  parameter logic [31:0] ROM_TOP  = fetch_pkg::ROM_TOP
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  input  logic [31:0] mem_rdata,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault
);

  logic [31:0]          pc;
  logic                 fault_hold;
  logic                 fetch;
  logic                 deq;
  logic                 exec_ok;
  fetch_entry_t         enq_entry;
  fetch_entry_t         head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  assign mem_addr  = pc;
  assign mem_wen   = 1'b0;
  assign exec_ok   = is_executable(pc, RAM_TOP, ROM_BASE, ROM_TOP);
  assign out_valid = (fifo_count != '0) && !redirect;
  assign deq       = out_valid && out_ready;
  assign fetch     = !redirect && !halt && !fault_hold && (!fifo_full || deq);

  always_comb begin
    enq_entry.pc    = pc;
    enq_entry.instr = mem_rdata;
    enq_entry.fault = 1'b0;
    if (!exec_ok) begin
      enq_entry.instr = 32'h0;
      enq_entry.fault = 1'b1;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch),
    .pop   (deq),
    .flush (redirect),
    .din   (enq_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head fields read as zero whenever nothing is queued.
  assign out_pc    = fifo_empty ? 32'h0 : head.pc;
  assign out_instr = fifo_empty ? 32'h0 : head.instr;
  assign out_fault = fifo_empty ? 1'b0  : head.fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      fault_hold <= 1'b0;
    end else if (redirect) begin
      pc         <= {redirect_pc[31:2], 2'b00};
      fault_hold <= 1'b0;
    end else if (fetch) begin
      // A faulting fetch parks the PC until decode redirects away.
      if (exec_ok) pc <= pc + 32'd4;
      else         fault_hold <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_rdata;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA55A, ~a[15:0]};
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_wen     (mem_wen),
    .mem_rdata   (mem_rdata),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_fault   (out_fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic fault);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_instr"}, out_instr, fault ? 32'h0 : mem_word(pc));
    check({tag, "_fault"}, {31'd0, out_fault}, {31'd0, fault});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  int valid_seen;

  initial begin
    rst = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    #3;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_fault", {31'd0, out_fault}, 32'd0);
    check("rst_wen", {31'd0, mem_wen}, 32'd0);
    check("rst_addr", mem_addr, 32'h0004_0000);
    tick();
    rst = 1'b0;
    #1;
    check("empty_after_rst", {31'd0, out_valid}, 32'd0);

    // Streaming with decode always ready.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_head($sformatf("stream%0d", i), 32'h0004_0000 + 32'(4 * i), 1'b0);
    end

    // Backpressure: FIFO fills to DEPTH and the PC stalls.
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    check("stall_addr", mem_addr, 32'h0004_0010);
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      #1;
      check_head($sformatf("drain%0d", i), 32'h0004_0000 + 32'(4 * i), 1'b0);
      tick();
    end
    check_head("refill", 32'h0004_0010, 1'b0);

    // Redirect with three entries queued.
    out_ready = 1'b0;
    do_reset();
    tick(); tick(); tick();
    check("three_queued_addr", mem_addr, 32'h0004_000C);
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    #1;
    check("redir_valid_low", {31'd0, out_valid}, 32'd0);
    tick();
    redirect = 1'b0; out_ready = 1'b1;
    #1;
    check("redir_flushed", {31'd0, out_valid}, 32'd0);
    check("redir_addr", mem_addr, 32'h0000_0100);
    tick();
    check_head("redir_first", 32'h0000_0100, 1'b0);

    // Redirect into IO space: one fault entry, then fetch stops.
    redirect = 1'b1; redirect_pc = 32'h0008_0000;
    tick();
    redirect = 1'b0;
    tick();
    check_head("io_fault", 32'h0008_0000, 1'b1);
    valid_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) valid_seen++;
    end
    check("io_no_more", 32'(valid_seen), 32'd0);
    check("io_pc_held", mem_addr, 32'h0008_0000);
    redirect = 1'b1; redirect_pc = 32'h0004_0000;
    tick();
    redirect = 1'b0;
    tick();
    check_head("io_resume", 32'h0004_0000, 1'b0);

    // Sequential fetch across the top of ROM.
    redirect = 1'b1; redirect_pc = 32'h0007_FFF8;
    tick();
    redirect = 1'b0;
    tick();
    check_head("romtop0", 32'h0007_FFF8, 1'b0);
    tick();
    check_head("romtop1", 32'h0007_FFFC, 1'b0);
    tick();
    check_head("romtop_fault", 32'h0008_0000, 1'b1);
    tick(); tick();
    check("romtop_stop", {31'd0, out_valid}, 32'd0);

    // Halt drains the queue and freezes the PC.
    out_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0004_0000;
    tick();
    redirect = 1'b0;
    tick(); tick();
    halt = 1'b1; out_ready = 1'b1;
    #1;
    check_head("halt0", 32'h0004_0000, 1'b0);
    tick();
    check_head("halt1", 32'h0004_0004, 1'b0);
    tick(); tick(); tick();
    check("halt_empty", {31'd0, out_valid}, 32'd0);
    check("halt_pc", mem_addr, 32'h0004_0008);

    // Redirect takes effect even while halted.
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    tick();
    redirect = 1'b0;
    #1;
    check("halt_redir_addr", mem_addr, 32'h0000_0200);
    tick();
    check("halt_redir_nofetch", {31'd0, out_valid}, 32'd0);
    halt = 1'b0;
    tick();
    check_head("halt_release", 32'h0000_0200, 1'b0);

    // Asynchronous reset mid-stream.
    #1;
    rst = 1'b1;
    #1;
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_addr", mem_addr, 32'h0004_0000);
    check("async_pc", out_pc, 32'h0);
    rst = 1'b0;
    tick();
    check_head("post_rst", 32'h0004_0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
